tlul_host_arb: RTL and testbench

// - Shares one TL-UL host port of xbar_main (e.g. the tl_spi_i slot) between NumHosts upstream requesters.
// - Requesters are the SPI bridge, the JTAG DTM and the boot loader.
// - Round-robin arbitration on channel A, with the grant locked until the beat is accepted.
// - Channel-D responses are routed back by source-ID tagging.
// - A per-host outstanding counter throttles each requester to MaxOutst transactions.

---
 rtl/tlul_host_arb_pkg.sv | 41 ++++
 rtl/prim_rr_pick.sv | 28 ++
 rtl/tlul_host_arb.sv | 181 ++++++++++++++++++
 tb/tb_tlul_host_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_host_arb_pkg.sv
// Shared types for the TL-UL host-port arbiter: bus structs, FSM states and sizing helpers.
package tlul_host_arb_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = TL_DW / 8;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef enum logic {StIdle, StLock} arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prim_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping at N-1.
module prim_rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] gnt_o,
  output logic            any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    j     = 0;
    // Scan farthest offset first so the nearest requester overwrites and wins.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % int'(N);
      if (req_i[j]) begin
        gnt_o = IdxW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// Shares one xbar TL-UL host port between NumHosts requesters: RR arbitration on A with the
// grant locked until acceptance, D routed back by source tag, per-host outstanding throttle.
module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter int unsigned NumHosts = 3,
  parameter int unsigned MaxOutst = 4,
  parameter int unsigned SrcW     = 5
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h_i [NumHosts],
  output tl_d2h_t tl_h_o [NumHosts],
  output tl_h2d_t tl_x_o,
  input  tl_d2h_t tl_x_i,
  output logic    busy_o,
  output logic    src_err_o
);

  localparam int unsigned IdxW = idx_w(NumHosts);
  localparam int unsigned CntW = $clog2(MaxOutst + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutst);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q [NumHosts];
  logic [CntW-1:0] cnt_d [NumHosts];
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [NumHosts-1:0] elig;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_any;

  always_comb begin
    for (int i = 0; i < int'(NumHosts); i++) begin
      elig[i] = tl_h_i[i].a_valid && (cnt_q[i] < MaxCnt);
    end
  end

  prim_rr_pick #(
    .N    (NumHosts),
    .IdxW (IdxW)
  ) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (pick_idx),
    .any_o (pick_any)
  );

  // A path: current owner is the locked grant or, in idle, the zero-cycle pick.
  logic [IdxW-1:0]   cur;
  logic              fwd;
  tl_h2d_t           a_sel;
  logic [TL_AIW-1:0] src_tag;
  logic              tag_err;
  logic              accept;

  always_comb begin
    cur   = (state_q == StLock) ? gnt_q : pick_idx;
    fwd   = !rst_i && ((state_q == StLock) || pick_any);
    a_sel = '0;
    for (int i = 0; i < int'(NumHosts); i++) begin
      if (cur == IdxW'(i)) a_sel = tl_h_i[i];
    end
    src_tag                 = '0;
    src_tag[SrcW-1:0]       = a_sel.a_source[SrcW-1:0];
    src_tag[SrcW +: IdxW]   = cur;
    tag_err                 = |a_sel.a_source[TL_AIW-1:SrcW];
  end

  // D path: decode the owning host from the tag bits.
  logic [IdxW-1:0]   d_idx;
  logic              d_bad;
  logic              d_rdy_sel;
  logic              d_cnt_zero;
  logic              d_fire;
  logic [TL_AIW-1:0] d_src_low;

  always_comb begin
    d_idx      = tl_x_i.d_source[SrcW +: IdxW];
    d_bad      = int'(d_idx) >= int'(NumHosts);
    d_rdy_sel  = 1'b0;
    d_cnt_zero = 1'b0;
    for (int i = 0; i < int'(NumHosts); i++) begin
      if (d_idx == IdxW'(i)) begin
        d_rdy_sel  = tl_h_i[i].d_ready;
        d_cnt_zero = (cnt_q[i] == '0);
      end
    end
    d_src_low           = '0;
    d_src_low[SrcW-1:0] = tl_x_i.d_source[SrcW-1:0];
  end

  always_comb begin
    tl_x_o          = a_sel;
    tl_x_o.a_valid  = fwd && a_sel.a_valid;
    tl_x_o.a_source = src_tag;
    tl_x_o.d_ready  = !rst_i && (d_bad || d_rdy_sel);
    accept          = tl_x_o.a_valid && tl_x_i.a_ready;
    d_fire          = tl_x_i.d_valid && tl_x_o.d_ready;
  end

  always_comb begin
    for (int i = 0; i < int'(NumHosts); i++) begin
      tl_h_o[i]          = tl_x_i;
      tl_h_o[i].a_ready  = fwd && (cur == IdxW'(i)) && tl_x_i.a_ready;
      tl_h_o[i].d_valid  = !rst_i && tl_x_i.d_valid && !d_bad && (d_idx == IdxW'(i));
      tl_h_o[i].d_source = d_src_low;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          err_d = tag_err;
          if (!tl_x_i.a_ready) begin
            state_d = StLock;
            gnt_d   = pick_idx;
          end
        end
      end
      StLock: begin
        if (!a_sel.a_valid) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (tl_x_i.a_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      ptr_d = (cur == IdxW'(NumHosts - 1)) ? '0 : cur + IdxW'(1);
    end
    if (d_fire && (d_bad || d_cnt_zero)) err_d = 1'b1;
  end

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < int'(NumHosts); i++) begin
      logic inc, dec;
      inc = accept && (cur == IdxW'(i));
      dec = d_fire && !d_bad && (d_idx == IdxW'(i)) && (cnt_q[i] != '0);
      unique case ({inc, dec})
        2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (cnt_d[i] != '0) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NumHosts); i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(NumHosts); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy_o    = busy_q;
  assign src_err_o = err_q;

endmodule

// File: tb/tb_tlul_host_arb.sv
// Scoreboard bench for tlul_host_arb: directed stimulus pushes expected A/D beats, a monitor checks them.
module tb_tlul_host_arb;
  import tlul_host_arb_pkg::*;

  localparam int unsigned NumHosts = 3;
  localparam int unsigned MaxOutst = 4;
  localparam int unsigned SrcW     = 5;
  localparam logic [31:0] ADDR_SPACE_PERI_DEVICE = 32'h4040_0000;

  logic    clk = 1'b0;
  logic    rst;
  tl_h2d_t tl_h_i [NumHosts];
  tl_d2h_t tl_h_o [NumHosts];
  tl_h2d_t tl_x_o;
  tl_d2h_t tl_x_i;
  logic    busy;
  logic    src_err;

  tlul_host_arb #(
    .NumHosts (NumHosts),
    .MaxOutst (MaxOutst),
    .SrcW     (SrcW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tl_h_i    (tl_h_i),
    .tl_h_o    (tl_h_o),
    .tl_x_o    (tl_x_o),
    .tl_x_i    (tl_x_i),
    .busy_o    (busy),
    .src_err_o (src_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [39:0] exp_a [$];  // {a_source, a_address}
  logic [9:0]  exp_d [$];  // {host index, d_source}

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int i, input logic v, input logic [7:0] src,
                          input logic [31:0] addr);
    tl_h_i[i].a_valid   = v;
    tl_h_i[i].a_opcode  = 3'h4;
    tl_h_i[i].a_source  = src;
    tl_h_i[i].a_address = addr;
    tl_h_i[i].a_mask    = 4'hf;
  endtask

  task automatic send_d(input logic [7:0] src);
    tl_x_i.d_valid  = 1'b1;
    tl_x_i.d_opcode = 3'h1;
    tl_x_i.d_source = src;
  endtask

  // Monitor: every beat the DUT presents must match the head of the expectation queues.
  always @(negedge clk) begin
    if (tl_x_o.a_valid && tl_x_i.a_ready) begin
      if (exp_a.size() == 0) chk("a_beat_unexpected", {24'h0, tl_x_o.a_source, tl_x_o.a_address}, 64'hdead);
      else chk("a_beat", {24'h0, tl_x_o.a_source, tl_x_o.a_address}, {24'h0, exp_a.pop_front()});
    end
    for (int i = 0; i < int'(NumHosts); i++) begin
      if (tl_h_o[i].d_valid) begin
        logic [9:0] got;
        got = {i[1:0], tl_h_o[i].d_source};
        if (exp_d.size() == 0) chk("d_beat_unexpected", {54'h0, got}, 64'hdead);
        else chk("d_beat", {54'h0, got}, {54'h0, exp_d.pop_front()});
      end
    end
  end

  initial begin
    logic any_ar, any_dv;
    rst    = 1'b1;
    tl_x_i = '0;
    for (int i = 0; i < int'(NumHosts); i++) begin
      tl_h_i[i]         = '0;
      tl_h_i[i].d_ready = 1'b1;
    end

    // Reset: random requests, xbar ready, a stray D beat; nothing may leak out.
    tl_x_i.a_ready = 1'b1;
    send_d(8'h20);
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int i = 0; i < int'(NumHosts); i++)
        set_host(i, (c == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 8'h01, 32'h0);
      #2;
      any_ar = 1'b0;
      any_dv = 1'b0;
      for (int i = 0; i < int'(NumHosts); i++) begin
        any_ar |= tl_h_o[i].a_ready;
        any_dv |= tl_h_o[i].d_valid;
      end
      chk("rst_x_a_valid", tl_x_o.a_valid, 0);
      chk("rst_a_ready", any_ar, 0);
      chk("rst_d_valid", any_dv, 0);
      chk("rst_x_d_ready", tl_x_o.d_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_src_err", src_err, 0);
    end
    tick();
    rst = 1'b0;
    tl_x_i.d_valid = 1'b0;

    // Round robin at full load: 0,1,2,0,1,2 with tagged sources.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < int'(NumHosts); i++)
        exp_a.push_back({8'(i << 5) | 8'(i + 1), 32'(32'h1000 * (i + 1))});
    for (int i = 0; i < int'(NumHosts); i++)
      set_host(i, 1'b1, 8'(i + 1), 32'(32'h1000 * (i + 1)));
    repeat (6) tick();
    for (int i = 0; i < int'(NumHosts); i++) set_host(i, 1'b0, 8'h0, 32'h0);
    #1;
    chk("rr_busy", busy, 1);
    chk("rr_src_err", src_err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_busy", busy, 0);

    // Host 1 alone, stalled for 5 cycles: grant must stay locked.
    tl_x_i.a_ready = 1'b0;
    set_host(1, 1'b1, 8'h03, ADDR_SPACE_PERI_DEVICE);
    repeat (5) begin
      #1;
      chk("lock_a_valid", tl_x_o.a_valid, 1);
      chk("lock_a_source", tl_x_o.a_source, 8'h23);
      chk("lock_a_ready", tl_h_o[1].a_ready, 0);
      tick();
    end
    exp_a.push_back({8'h23, ADDR_SPACE_PERI_DEVICE});
    tl_x_i.a_ready = 1'b1;
    tick();
    set_host(1, 1'b0, 8'h0, 32'h0);
    tl_x_i.a_ready = 1'b0;
    #1;
    chk("lock_busy_after_accept", busy, 1);
    send_d(8'h23);
    exp_d.push_back({2'd1, 8'h03});
    #1;
    chk("d_route_d_ready", tl_x_o.d_ready, 1);
    tick();
    tl_x_i.d_valid = 1'b0;
    #1;
    chk("d_route_busy_cleared", busy, 0);
    chk("d_route_src_err", src_err, 0);

    // Host 0 saturates at MaxOutst; host 2 is served meanwhile; a D return frees a slot.
    tl_x_i.a_ready = 1'b1;
    repeat (MaxOutst) exp_a.push_back({8'h01, 32'h100});
    set_host(0, 1'b1, 8'h01, 32'h100);
    repeat (MaxOutst) tick();
    #1;
    chk("sat_blocked", tl_x_o.a_valid, 0);
    exp_a.push_back({8'h42, 32'h300});
    set_host(2, 1'b1, 8'h02, 32'h300);
    #1;
    chk("sat_other_host_served", tl_x_o.a_valid, 1);
    tick();
    set_host(2, 1'b0, 8'h0, 32'h0);
    #1;
    chk("sat_still_blocked", tl_x_o.a_valid, 0);
    send_d(8'h01);
    exp_d.push_back({2'd0, 8'h01});
    tick();
    tl_x_i.d_valid = 1'b0;
    exp_a.push_back({8'h01, 32'h100});
    #1;
    chk("sat_regranted", tl_x_o.a_valid, 1);
    tick();
    set_host(0, 1'b0, 8'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // D beat with an out-of-range host index is sunk and flagged once.
    for (int i = 0; i < int'(NumHosts); i++) tl_h_i[i].d_ready = 1'b0;
    send_d(8'h65);
    #1;
    chk("sink_d_ready", tl_x_o.d_ready, 1);
    tick();
    tl_x_i.d_valid = 1'b0;
    for (int i = 0; i < int'(NumHosts); i++) tl_h_i[i].d_ready = 1'b1;
    #1;
    chk("sink_src_err_pulse", src_err, 1);
    tick();
    chk("sink_src_err_once", src_err, 0);

    // Host 2: simultaneous accept and D return keeps the count at 2, so only 2 more fit.
    tl_x_i.a_ready = 1'b1;
    repeat (2) exp_a.push_back({8'h44, 32'h200});
    set_host(2, 1'b1, 8'h04, 32'h200);
    repeat (2) tick();
    exp_a.push_back({8'h44, 32'h200});
    send_d(8'h44);
    exp_d.push_back({2'd2, 8'h04});
    tick();
    tl_x_i.d_valid = 1'b0;
    repeat (2) exp_a.push_back({8'h44, 32'h200});
    repeat (2) tick();
    #1;
    chk("same_cycle_cnt_held", tl_x_o.a_valid, 0);
    chk("same_cycle_src_err", src_err, 0);
    set_host(2, 1'b0, 8'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    send_d(8'h44);
    exp_d.push_back({2'd2, 8'h04});
    tick();
    tl_x_i.d_valid = 1'b0;
    #1;
    chk("late_d_src_err", src_err, 1);
    chk("late_d_no_underflow", busy, 0);
    tick();
    chk("late_d_src_err_clear", src_err, 0);
    chk("late_d_busy_final", busy, 0);

    tick();
    chk("a_queue_drained", exp_a.size(), 0);
    chk("d_queue_drained", exp_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
